// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: FSM states, coin values
// in nickel units, and the width of the owed-amount datapath.
package change_dispenser_pkg;

  localparam int AMT_W = 5;

  localparam logic [AMT_W-1:0] DIME_UNITS   = 5'd2;
  localparam logic [AMT_W-1:0] NICKEL_UNITS = 5'd1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHOOSE = 3'd1,
    WAIT_D = 3'd2,
    WAIT_N = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/change_timer.sv
// Per-coin Ack wait counter. expired is high during the TIMEOUT-th enabled
// cycle since the last clear, so the owner leaves the wait after exactly TIMEOUT cycles.
module change_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [3:0] count;

  assign expired = enable && (count == 4'(TIMEOUT - 1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy dime/nickel change dispenser. One coin request is held per WAIT state
// until the ejector acknowledges it or the per-coin timer expires.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [AMT_W-1:0] Amount,
  input  logic             DimeAvail,
  input  logic             NickelAvail,
  input  logic             Ack,
  output logic             DispD,
  output logic             DispN,
  output logic             Busy,
  output logic             Done,
  output logic             Short,
  output logic [AMT_W-1:0] Remaining,
  output state_t           DbgState
);

  state_t           state, state_next;
  logic [AMT_W-1:0] rem_next;
  logic             short_next;
  logic             in_wait;
  logic             expired;

  assign in_wait = (state == WAIT_D) || (state == WAIT_N);

  // Timer is held clear outside the WAIT states, so every WAIT entry starts at zero.
  change_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (expired)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      Remaining <= '0;
      Short     <= 1'b0;
    end else begin
      state     <= state_next;
      Remaining <= rem_next;
      Short     <= short_next;
    end
  end

  always_comb begin
    state_next = state;
    rem_next   = Remaining;
    short_next = Short;
    case (state)
      IDLE: begin
        if (Start) begin
          rem_next   = Amount;
          short_next = 1'b0;
          state_next = CHOOSE;
        end
      end
      CHOOSE: begin
        if (Remaining == '0) begin
          state_next = DONE;
        end else if (Remaining >= DIME_UNITS && DimeAvail) begin
          state_next = WAIT_D;
        end else if (Remaining >= NICKEL_UNITS && NickelAvail) begin
          state_next = WAIT_N;
        end else begin
          short_next = 1'b1;
          state_next = DONE;
        end
      end
      WAIT_D, WAIT_N: begin
        // Ack takes precedence over a timeout landing in the same cycle.
        if (Ack) begin
          if (state == WAIT_D) begin
            rem_next = (Remaining >= DIME_UNITS) ? Remaining - DIME_UNITS : '0;
          end else begin
            rem_next = (Remaining >= NICKEL_UNITS) ? Remaining - NICKEL_UNITS : '0;
          end
          state_next = CHOOSE;
        end else if (expired) begin
          short_next = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign DispD    = (state == WAIT_D);
  assign DispN    = (state == WAIT_N);
  assign Busy     = (state != IDLE);
  assign Done     = (state == DONE);
  assign DbgState = state;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum cycles to wait for Ack per coin (range 1..15).
REQ-002 The block SHALL have port Clock  input  1  rising-edge system clock.
REQ-003 The block SHALL have port Resetn  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port Start  input  1  request to dispense Amount; sampled only in IDLE.
REQ-005 The block SHALL have port Amount  input  5  change owed in nickel units (5 cents each), 0..31.
REQ-006 The block SHALL have port DimeAvail  input  1  dime hopper not empty.
REQ-007 The block SHALL have port NickelAvail  input  1  nickel hopper not empty.
REQ-008 The block SHALL have port Ack  input  1  ejection mechanism reports one coin released.
REQ-009 The block SHALL have port DispD  output  1  eject-one-dime request, held until Ack or timeout.
REQ-010 The block SHALL have port DispN  output  1  eject-one-nickel request, held until Ack or timeout.
REQ-011 The block SHALL have port Busy  output  1  high in every state except IDLE.
REQ-012 The block SHALL have port Done  output  1  one-cycle pulse at job end.
REQ-013 The block SHALL have port Short  output  1  last job ended with change still owed; held until next accepted Start.
REQ-014 The block SHALL have port Remaining  output  5  nickel units still owed.

Function
REQ-015 The FSM SHALL have states IDLE, CHOOSE, WAIT_D, WAIT_N, DONE; outputs DispD/DispN/Busy/Done SHALL be Moore-decoded from state.
REQ-016 In IDLE with Start=1 at a clock edge, the block SHALL load Remaining<=Amount, clear Short, and go to CHOOSE.
REQ-017 In CHOOSE, selection SHALL be greedy, with priority: Remaining==0 -> DONE; Remaining>=2 and DimeAvail -> WAIT_D; Remaining>=1 and NickelAvail -> WAIT_N; otherwise -> DONE with Short<=1.
REQ-018 In WAIT_D/WAIT_N, Ack=1 at an edge SHALL subtract 2/1 from Remaining and go to CHOOSE; Remaining SHALL never underflow.
REQ-019 The wait counter SHALL reset on entry to each WAIT state; if TIMEOUT cycles elapse without Ack, the block SHALL go to DONE with Short<=1 and Remaining unchanged.
REQ-020 If Ack and timeout occur in the same cycle, Ack SHALL win.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-022 Ack outside WAIT states SHALL be ignored, and Start outside IDLE SHALL be ignored.
REQ-023 Amount=0 SHALL produce Done two cycles after the Start edge (IDLE->CHOOSE->DONE) with Short=0.
REQ-024 Per-coin latency SHALL be: CHOOSE 1 cycle, plus WAIT until Ack, plus back to CHOOSE.
REQ-025 Hopper inputs SHALL be sampled only in CHOOSE; a hopper emptying during a WAIT state SHALL NOT abort the pending coin.

Reset
REQ-026 Resetn=0 SHALL, asynchronously, force state IDLE, Remaining=0, Short=0, wait counter=0, and thereby DispD=DispN=Busy=Done=0.
REQ-027 Reset mid-job SHALL abandon the job without a Done pulse; after release, the block SHALL accept a new Start.

Structure
REQ-028 A shared package SHALL hold the state enumeration, coin values (DIME_UNITS=2, NICKEL_UNITS=1) and the Amount width (5).
REQ-029 The wait counter SHALL be the sub-module change_timer (clear, enable, expired output at TIMEOUT).

Verification
REQ-030 The bench SHALL drive Amount=7, both hoppers full, Ack 2 cycles after each request -> DispD x3 then DispN x1, Remaining 7->5->3->1->0, Done pulse, Short=0.
REQ-031 The bench SHALL drive Amount=4 with DimeAvail=0 -> DispN x4, Done, Short=0.
REQ-032 The bench SHALL drive Amount=3 with NickelAvail=0 -> one DispD, then DONE with Remaining=1 and Short=1.
REQ-033 The bench SHALL hold Ack=0 with Amount=2 -> DispD high for exactly TIMEOUT cycles, then Done, Short=1, Remaining=2.
REQ-034 The bench SHALL assert Resetn=0 during WAIT_D -> all outputs 0 immediately, with no Done; then Start with Amount=1 completes normally.
REQ-035 The bench SHALL drive Amount=0, and separately Start during Busy and a stray Ack in IDLE -> Done after 2 cycles; the Start and Ack SHALL have no effect.
